// File: rtl/target_lut.sv
// RAM-backed branch-target lookup table with registered reads and an init fill sequencer.
// Optional per-entry absolute-target flag and WrAbs port enabled by defining TARGET_LUT_ABS_EN.
module target_lut #(
    parameter int DEPTH   = 16,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int DATA_W  = 11,
    parameter int PC_W    = 10,
    parameter int DEFAULT = 1
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Flush,
    input  logic              RdEn,
    input  logic [IDX_W-1:0]  Index,
    input  logic [PC_W-1:0]   PC,
    input  logic              WrEn,
    input  logic [IDX_W-1:0]  WrIndex,
    input  logic [DATA_W-1:0] WrData,
`ifdef TARGET_LUT_ABS_EN
    input  logic              WrAbs,
`endif
    output logic [DATA_W-1:0] Out,
    output logic [PC_W-1:0]   Target,
    output logic              OutValid,
    output logic              Busy
);

    typedef enum logic {
        S_INIT  = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_init_ptr;
    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [DATA_W-1:0]  r_out;
    logic [PC_W-1:0]    r_target;
    logic               r_out_valid;

    logic               w_bypass;
    logic [DATA_W-1:0]  w_rd_data;
    logic [PC_W-1:0]    w_ext_rel;
    logic [PC_W-1:0]    w_target;

    assign w_bypass  = WrEn && (WrIndex == Index);
    assign w_rd_data = w_bypass ? WrData : r_mem[Index];

    // Entry is sign-extended to PC width, or truncated when it is wider than the PC.
    generate
        if (DATA_W >= PC_W) begin : g_rel_trunc
            assign w_ext_rel = w_rd_data[PC_W-1:0];
        end else begin : g_rel_sext
            assign w_ext_rel = {{(PC_W-DATA_W){w_rd_data[DATA_W-1]}}, w_rd_data};
        end
    endgenerate

`ifdef TARGET_LUT_ABS_EN
    logic               r_abs [DEPTH];
    logic               w_rd_abs;
    logic [PC_W-1:0]    w_ext_abs;

    assign w_rd_abs = w_bypass ? WrAbs : r_abs[Index];

    generate
        if (DATA_W >= PC_W) begin : g_abs_trunc
            assign w_ext_abs = w_rd_data[PC_W-1:0];
        end else begin : g_abs_zext
            assign w_ext_abs = {{(PC_W-DATA_W){1'b0}}, w_rd_data};
        end
    endgenerate

    // Target select: flagged entries ignore the PC.
    always_comb begin
        w_target = PC + w_ext_rel;
        if (w_rd_abs) begin
            w_target = w_ext_abs;
        end else begin
            w_target = PC + w_ext_rel;
        end
    end

    // Absolute-flag storage, cleared by the init fill and written alongside the entry.
    always_ff @(posedge Clk) begin
        if (r_state == S_INIT) begin
            r_abs[r_init_ptr] <= 1'b0;
        end else if (WrEn) begin
            r_abs[WrIndex] <= WrAbs;
        end
    end
`else
    assign w_target = PC + w_ext_rel;
`endif

    // Table storage: init fill has priority; a write alongside Flush lands and is then refilled.
    always_ff @(posedge Clk) begin
        if (r_state == S_INIT) begin
            r_mem[r_init_ptr] <= DATA_W'(DEFAULT);
        end else if (WrEn) begin
            r_mem[WrIndex] <= WrData;
        end
    end

    // Control FSM and registered read outputs.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state     <= S_INIT;
            r_init_ptr  <= {IDX_W{1'b0}};
            r_out       <= {DATA_W{1'b0}};
            r_target    <= {PC_W{1'b0}};
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= 1'b0;
            case (r_state)
                S_INIT: begin
                    if (r_init_ptr == IDX_W'(DEPTH - 1)) begin
                        r_state    <= S_READY;
                        r_init_ptr <= {IDX_W{1'b0}};
                    end else begin
                        r_init_ptr <= r_init_ptr + 1'b1;
                    end
                end
                S_READY: begin
                    if (RdEn) begin
                        r_out       <= w_rd_data;
                        r_target    <= w_target;
                        r_out_valid <= 1'b1;
                    end
                    if (Flush) begin
                        r_state    <= S_INIT;
                        r_init_ptr <= {IDX_W{1'b0}};
                    end
                end
                default: begin
                    r_state    <= S_INIT;
                    r_init_ptr <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign Out      = r_out;
    assign Target   = r_target;
    assign OutValid = r_out_valid;
    assign Busy     = (r_state == S_INIT);

endmodule

// File: tb/tb_target_lut.sv
// Directed self-checking bench for target_lut (DEPTH=16, DATA_W=11, PC_W=10).
// Absolute-target steps run only when TARGET_LUT_ABS_EN is defined.
module tb_target_lut;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Flush = 1'b0;
    logic        RdEn = 1'b0;
    logic [3:0]  Index = 4'd0;
    logic [9:0]  PC = 10'd0;
    logic        WrEn = 1'b0;
    logic [3:0]  WrIndex = 4'd0;
    logic [10:0] WrData = 11'd0;
`ifdef TARGET_LUT_ABS_EN
    logic        WrAbs = 1'b0;
`endif
    logic [10:0] Out;
    logic [9:0]  Target;
    logic        OutValid;
    logic        Busy;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;

    target_lut dut (
        .Clk      (Clk),
        .Reset    (Reset),
        .Flush    (Flush),
        .RdEn     (RdEn),
        .Index    (Index),
        .PC       (PC),
        .WrEn     (WrEn),
        .WrIndex  (WrIndex),
        .WrData   (WrData),
`ifdef TARGET_LUT_ABS_EN
        .WrAbs    (WrAbs),
`endif
        .Out      (Out),
        .Target   (Target),
        .OutValid (OutValid),
        .Busy     (Busy)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic wr(input logic [3:0] idx, input logic [10:0] data);
        WrIndex = idx;
        WrData  = data;
        WrEn    = 1'b1;
        step();
        WrEn    = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [3:0] idx, input logic [9:0] pc,
                      input logic [10:0] exp_out, input logic [9:0] exp_tgt);
        Index = idx;
        PC    = pc;
        RdEn  = 1'b1;
        step();
        RdEn  = 1'b0;
        chk(tag, {11'd0, OutValid, Out, Target}, {11'd0, 1'b1, exp_out, exp_tgt});
    endtask

    // Counts edges until Busy drops, bounded so a stuck DUT still reaches the summary.
    task automatic busy_len(input string tag);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!Busy) break;
            step();
            cnt++;
        end
        chk(tag, 32'(cnt), 32'd16);
    endtask

    initial begin
        int vcnt;
        step();
        step();
        chk("reset_state", {20'd0, Busy, OutValid, Out, Target}, {20'd0, 1'b1, 1'b0, 11'd0, 10'd0});

        // Release reset; requests during init must be dropped.
        Reset   = 1'b0;
        RdEn    = 1'b1;
        Index   = 4'd3;
        WrEn    = 1'b1;
        WrIndex = 4'd3;
        WrData  = 11'd9;
        vcnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (!Busy) break;
            step();
            if (OutValid) vcnt++;
        end
        RdEn = 1'b0;
        WrEn = 1'b0;
        chk("init_no_valid", 32'(vcnt), 32'd0);
        chk("init_busy_len_idle", 32'(Busy), 32'd0);

        for (int i = 0; i < 16; i++) begin
            rd($sformatf("default_idx%0d", i), 4'(i), 10'(i * 37), 11'd1, 10'(i * 37 + 1));
        end

        // Negative entry, wrapping target, single-cycle OutValid and hold.
        wr(4'd0, 11'h68E);
        rd("neg_entry", 4'd0, 10'd5, 11'h68E, 10'd659);
        step();
        chk("valid_pulse_hold", {20'd0, OutValid, Out}, {20'd0, 1'b0, 11'h68E});

        // Write-first bypass on the same index.
        Index   = 4'd7;
        PC      = 10'd400;
        RdEn    = 1'b1;
        WrEn    = 1'b1;
        WrIndex = 4'd7;
        WrData  = 11'h69B;
        step();
        RdEn = 1'b0;
        WrEn = 1'b0;
        chk("bypass", {11'd0, OutValid, Out, Target}, {11'd0, 1'b1, 11'h69B, 10'd43});
        rd("bypass_next", 4'd7, 10'd400, 11'h69B, 10'd43);

        // Independent read and write to different indices.
        Index   = 4'd4;
        PC      = 10'd100;
        RdEn    = 1'b1;
        WrEn    = 1'b1;
        WrIndex = 4'd5;
        WrData  = 11'd20;
        step();
        RdEn = 1'b0;
        WrEn = 1'b0;
        chk("diff_idx_read", {11'd0, OutValid, Out, Target}, {11'd0, 1'b1, 11'd1, 10'd101});
        rd("diff_idx_write", 4'd5, 10'd100, 11'd20, 10'd120);

        // Fill 15 entries, then Flush together with a read that is still serviced.
        for (int i = 1; i < 16; i++) wr(4'(i), 11'(100 + i));
        rd("pre_flush", 4'd9, 10'd0, 11'd109, 10'd109);
        Index = 4'd1;
        PC    = 10'd0;
        RdEn  = 1'b1;
        Flush = 1'b1;
        step();
        RdEn  = 1'b0;
        Flush = 1'b0;
        chk("flush_read", {11'd0, OutValid, Out, Target}, {11'd0, 1'b1, 11'd101, 10'd101});
        busy_len("flush_busy_len");
        for (int i = 0; i < 16; i++) begin
            rd($sformatf("post_flush_idx%0d", i), 4'(i), 10'd1000, 11'd1, 10'd1001);
        end

        // Reset at init cycle 5 aborts and restarts the fill.
        Flush = 1'b1;
        step();
        Flush = 1'b0;
        for (int i = 0; i < 5; i++) step();
        Reset = 1'b1;
        #2;
        chk("mid_init_reset", {20'd0, Busy, OutValid, Out, Target}, {20'd0, 1'b1, 1'b0, 11'd0, 10'd0});
        step();
        Reset = 1'b0;
        busy_len("reset_busy_len");
        rd("after_reset_idx15", 4'd15, 10'd1023, 11'd1, 10'd0);

`ifdef TARGET_LUT_ABS_EN
        WrAbs = 1'b1;
        wr(4'd2, 11'd300);
        rd("abs_target", 4'd2, 10'd900, 11'd300, 10'd300);
        WrAbs = 1'b0;
        wr(4'd2, 11'd300);
        rd("rel_target", 4'd2, 10'd900, 11'd300, 10'd176);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
